// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory block: MMIO decode select,
// register offsets (word index within the MMIO window) and STATUS bit positions.
package dmem_pkg;

  localparam logic [3:0] MMIO_SEL     = 4'h1;

  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_MTIME    = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP = 3'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_IRQ   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head/tail pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-port memory: word RAM plus an MMIO window holding a TX byte FIFO,
// a free-running timer with compare interrupt, and a STATUS register.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        timer_irq_o
);

  logic [31:0]       ram [2**ADDR_W];
  logic              is_mmio;
  logic [2:0]        reg_sel;
  logic [ADDR_W-1:0] ram_idx;
  logic              wr;
  logic              mmio_wr;
  logic              push_req;
  logic              wr_status;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       mtime;
  logic [31:0]       mtimecmp;
  logic              irq;
  logic              ovf;
  logic [31:0]       status;
  logic              unused_addr;

  assign is_mmio   = (addr_i[31:28] == MMIO_SEL);
  assign reg_sel   = addr_i[4:2];
  assign ram_idx   = addr_i[ADDR_W+1:2];
  assign wr        = ce_i && we_i;
  assign mmio_wr   = wr && is_mmio;
  assign push_req  = mmio_wr && (reg_sel == OFF_TXDATA);
  assign wr_status = mmio_wr && (reg_sel == OFF_STATUS);
  assign pop       = tx_valid_o && tx_ready_i;

  assign tx_valid_o  = !fifo_empty;
  assign timer_irq_o = irq;
  assign unused_addr = ^{addr_i[27:ADDR_W+2], addr_i[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wdata_i[7:0]),
    .pop   (pop),
    .rdata (tx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr && !is_mmio) ram[ram_idx] <= wdata_i;
  end

  // Compare uses the pre-edge mtime; a match beats a same-cycle software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      irq      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (mmio_wr && reg_sel == OFF_MTIME) mtime <= wdata_i;
      else                                 mtime <= mtime + 32'd1;
      if (mmio_wr && reg_sel == OFF_MTIMECMP) mtimecmp <= wdata_i;
      if (mtime == mtimecmp)                 irq <= 1'b1;
      else if (wr_status && wdata_i[ST_IRQ]) irq <= 1'b0;
      if (push_req && fifo_full && !pop)     ovf <= 1'b1;
      else if (wr_status && wdata_i[ST_OVF]) ovf <= 1'b0;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf;
    status[ST_IRQ]   = irq;
  end

  always_comb begin
    rdata_o = '0;
    if (ce_i) begin
      if (is_mmio) begin
        case (reg_sel)
          OFF_STATUS:   rdata_o = status;
          OFF_MTIME:    rdata_o = mtime;
          OFF_MTIMECMP: rdata_o = mtimecmp;
          default:      rdata_o = '0;
        endcase
      end else begin
        rdata_o = ram[ram_idx];
      end
    end
  end

endmodule
